pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 108 ++++++++++
 tb/tb_pipelined_addsub.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master side drives operands and the result-side ready; the slave side
// (the arithmetic unit) drives the input-side ready and the result beat.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into STAGES
// chunks of CHUNK bits; each stage resolves one chunk and registers its carry,
// operands travel forward so higher chunks can be resolved later. The whole
// pipeline advances as one (global stall) whenever the result slot is free or
// being consumed.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_addsub_if.slave  bus
);
    localparam int CHUNK = (STAGES >= 1) ? (WIDTH / STAGES) : WIDTH;

    generate
        if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
        end
    endgenerate

    // Per-stage pipeline state: valid, operands (B already conditioned), the
    // partial sum resolved so far, and the carry out of the resolved chunk.
    logic             vld_r   [STAGES];
    logic [WIDTH-1:0] a_r     [STAGES];
    logic [WIDTH-1:0] bp_r    [STAGES];
    logic [WIDTH-1:0] sum_r   [STAGES];
    logic             carry_r [STAGES];

    // Values feeding each stage (from the input port or the previous stage).
    logic             src_v_s   [STAGES];
    logic [WIDTH-1:0] src_a_s   [STAGES];
    logic [WIDTH-1:0] src_bp_s  [STAGES];
    logic [WIDTH-1:0] src_sum_s [STAGES];
    logic             src_c_s   [STAGES];
    logic [WIDTH-1:0] nxt_sum_s [STAGES];
    logic             nxt_c_s   [STAGES];
    logic [CHUNK:0]   chunk_s;
    logic             adv_s;

    // Pipeline enable: shift when the result slot is empty or being taken.
    always_comb begin
        adv_s = bus.out_ready | ~vld_r[STAGES-1];
    end

    // Select what each stage consumes; stage 0 conditions B and the carry-in
    // for subtract mode (A + ~B + 1), later stages take the previous register.
    always_comb begin
        src_v_s[0]   = bus.in_valid;
        src_a_s[0]   = bus.a;
        src_bp_s[0]  = bus.sub ? ~bus.b : bus.b;
        src_c_s[0]   = bus.sub ? 1'b1 : bus.cin;
        src_sum_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k]   = vld_r[k-1];
            src_a_s[k]   = a_r[k-1];
            src_bp_s[k]  = bp_r[k-1];
            src_c_s[k]   = carry_r[k-1];
            src_sum_s[k] = sum_r[k-1];
        end
    end

    // Chunk adders: CHUNK+1 bits wide so the top bit is the chunk carry; lower
    // resolved chunks pass through untouched.
    always_comb begin
        chunk_s = {(CHUNK+1){1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            chunk_s = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]}
                    + {1'b0, src_bp_s[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, src_c_s[k]};
            nxt_sum_s[k] = src_sum_s[k];
            nxt_sum_s[k][k*CHUNK +: CHUNK] = chunk_s[CHUNK-1:0];
            nxt_c_s[k] = chunk_s[CHUNK];
        end
    end

    // Stage registers: reset discards in-flight beats, otherwise all stages
    // shift together on adv and hold (bubbles included) while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k]   <= 1'b0;
                a_r[k]     <= {WIDTH{1'b0}};
                bp_r[k]    <= {WIDTH{1'b0}};
                sum_r[k]   <= {WIDTH{1'b0}};
                carry_r[k] <= 1'b0;
            end
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k]   <= src_v_s[k];
                a_r[k]     <= src_a_s[k];
                bp_r[k]    <= src_bp_s[k];
                sum_r[k]   <= nxt_sum_s[k];
                carry_r[k] <= nxt_c_s[k];
            end
        end
    end

    // Result side comes straight from the final stage registers; ovf is a pure
    // function of those registers, so it is as stable as sum and cout and
    // reads 0 out of reset (all-zero operands and sum).
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = vld_r[STAGES-1];
    assign bus.sum       = sum_r[STAGES-1];
    assign bus.cout      = carry_r[STAGES-1];
    assign bus.ovf       = (a_r[STAGES-1][WIDTH-1] == bp_r[STAGES-1][WIDTH-1])
                         & (sum_r[STAGES-1][WIDTH-1] != a_r[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vector table, streaming,
// stall and reset sequences on a 32/4 instance, plus randomized sweeps of
// (16,1), (16,16) and (64,8) instances against a plain-arithmetic model.
module tb_pipelined_addsub;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst_sw;
    int   errors = 0;
    int   checks = 0;
    bit   sw_done [3];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(W)) bus ();
    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference: {ovf, cout, sum} from integer arithmetic on w-bit operands.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] x_in,
                                           input logic [63:0] y_in, input logic ci,
                                           input logic sb);
        logic [63:0] mask, x, y, s;
        logic [64:0] full;
        logic        co, ov, sx, sy, ss;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = x_in & mask;
        y = y_in & mask;
        if (!sb) begin
            full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            s    = full[63:0] & mask;
            co   = full[w];
        end else begin
            s  = (x - y) & mask;
            co = (x >= y);
        end
        sx = x[w-1];
        sy = y[w-1];
        ss = s[w-1];
        ov = sb ? ((sx != sy) && (ss != sx)) : ((sx == sy) && (ss != sx));
        return {ov, co, s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    // Stream n random beats with in_valid held; optional out_ready=0 window.
    task automatic run_stream(input int n, input int stall_at, input int stall_len);
        logic [31:0] ta [32];
        logic [31:0] tb [32];
        logic        tc [32];
        logic        ts [32];
        logic [65:0] ex [32];
        logic [31:0] h_sum;
        logic        h_c, h_o, stalled;
        bit          frozen_ok = 1'b1, ready_ok = 1'b1;
        int sent = 0, recv = 0, cyc = 0, first_acc = -1, first_out = -1, last_out = -1;
        for (int i = 0; i < n; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
            tc[i] = 1'($urandom_range(0, 1));
            ts[i] = 1'($urandom_range(0, 1));
            ex[i] = ref_op(32, {32'd0, ta[i]}, {32'd0, tb[i]}, tc[i], ts[i]);
        end
        while (recv < n && cyc < 300) begin
            @(negedge clk);
            stalled = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
            bus.out_ready = !stalled;
            if (sent < n) begin
                bus.in_valid = 1'b1;
                bus.a = ta[sent]; bus.b = tb[sent]; bus.cin = tc[sent]; bus.sub = ts[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                if (cyc == stall_at) begin
                    h_sum = bus.sum; h_c = bus.cout; h_o = bus.ovf;
                end else if (bus.sum !== h_sum || bus.cout !== h_c || bus.ovf !== h_o || bus.out_valid !== 1'b1) begin
                    frozen_ok = 1'b0;
                end
                if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                check("stream sum", 64'(bus.sum), {32'd0, ex[recv][31:0]});
                check("stream cout", 64'(bus.cout), 64'(ex[recv][64]));
                check("stream ovf", 64'(bus.ovf), 64'(ex[recv][65]));
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream beats out", 64'(recv), 64'(n));
        check("stream latency", 64'(first_out - first_acc), 64'(S));
        check("stream span", 64'(last_out - first_out), 64'(n - 1 + stall_len));
        if (stall_at >= 0) begin
            check("stall frozen", 64'(frozen_ok), 64'd1);
            check("stall in_ready low", 64'(ready_ok), 64'd1);
        end
    endtask

    // Randomized sweep of other parameter points, each on its own instance.
    localparam int SWW [3] = '{16, 16, 64};
    localparam int SWS [3] = '{1, 16, 8};

    for (genvar g = 0; g < 3; g++) begin : sweep
        localparam int WW = SWW[g];
        localparam int SS = SWS[g];
        pipelined_addsub_if #(.WIDTH(WW)) sbus ();
        pipelined_addsub #(.WIDTH(WW), .STAGES(SS)) sdut (.clk(clk), .rst(rst_sw), .bus(sbus));
        logic [65:0] exp_q [$];
        int          stamp_q [$];

        initial begin
            logic [63:0] ra, rb;
            logic [65:0] e;
            int adv_cnt = 0, got = 0, sent = 0, cyc = 0, st = 0;
            sbus.in_valid = 1'b0; sbus.out_ready = 1'b0;
            sbus.a = '0; sbus.b = '0; sbus.cin = 1'b0; sbus.sub = 1'b0;
            ra = '0; rb = '0;
            @(negedge clk);
            while (rst_sw !== 1'b0) @(negedge clk);
            while (got < 40 && cyc < 3000) begin
                @(negedge clk);
                sbus.out_ready = ($urandom_range(0, 3) != 0);
                if (sent < 40 && $urandom_range(0, 3) != 0) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    sbus.in_valid = 1'b1;
                    sbus.a   = ra[WW-1:0];
                    sbus.b   = rb[WW-1:0];
                    sbus.cin = 1'($urandom_range(0, 1));
                    sbus.sub = 1'($urandom_range(0, 1));
                end else begin
                    sbus.in_valid = 1'b0;
                end
                #1;
                if (sbus.out_valid && sbus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sweep unexpected beat", 64'd1, 64'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        st = stamp_q.pop_front();
                        check("sweep sum", 64'(sbus.sum), e[63:0]);
                        check("sweep cout", 64'(sbus.cout), 64'(e[64]));
                        check("sweep ovf", 64'(sbus.ovf), 64'(e[65]));
                        check("sweep latency", 64'(adv_cnt - st), 64'(SS));
                    end
                    got++;
                end
                if (sbus.in_valid && sbus.in_ready) begin
                    exp_q.push_back(ref_op(WW, ra, rb, sbus.cin, sbus.sub));
                    stamp_q.push_back(adv_cnt);
                    sent++;
                end
                if (sbus.in_ready) adv_cnt++;
                cyc++;
            end
            check("sweep beats out", 64'(got), 64'd40);
            sw_done[g] = 1'b1;
        end
    end

    initial begin
        vec_t vecs [8];
        int   lat;
        int   vcount;
        int   guard;
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

        rst = 1'b1; rst_sw = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_sw = 1'b0;
        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset sum", 64'(bus.sum), 64'd0);
        check("reset cout", 64'(bus.cout), 64'd0);
        check("reset ovf", 64'(bus.ovf), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);

        // Directed single beats from the table, one at a time.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.a = vecs[i].a; bus.b = vecs[i].b; bus.cin = vecs[i].cin; bus.sub = vecs[i].sub;
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("vec latency", 64'(lat), 64'(S));
            check("vec sum", 64'(bus.sum), {32'd0, vecs[i].sum});
            check("vec cout", 64'(bus.cout), 64'(vecs[i].cout));
            check("vec ovf", 64'(bus.ovf), 64'(vecs[i].ovf));
        end
        repeat (2) @(negedge clk);

        run_stream(16, -1, 0);
        repeat (2) @(negedge clk);
        run_stream(20, 8, 6);
        repeat (2) @(negedge clk);

        // Reset with three beats in flight: none may emerge afterwards.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a = $urandom; bus.b = $urandom; bus.cin = 1'b1; bus.sub = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush sum", 64'(bus.sum), 64'd0);
        check("flush cout", 64'(bus.cout), 64'd0);
        check("flush ovf", 64'(bus.ovf), 64'd0);
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) vcount++;
        end
        check("flush no stale beat", 64'(vcount), 64'd0);

        guard = 0;
        while (!(sw_done[0] && sw_done[1] && sw_done[2]) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("sweep completion", 64'(sw_done[0] && sw_done[1] && sw_done[2]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
